uart_rx_ctrl: RTL and testbench

//  Receive-side controller for the UART_RX datapath in the MIPS SoC. Watches the receiver's

---
 rtl/uart_rx_ctrl_pkg.sv | 23 ++
 rtl/uart_rx_ctrl_if.sv | 23 ++
 rtl/uart_rx_ctrl_fifo.sv | 51 +++++
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map, STATUS/CTRL bit positions, FSM states.
package uart_rx_ctrl_pkg;

    localparam logic [3:0] UART_RX_DATA   = 4'h0;
    localparam logic [3:0] UART_RX_STATUS = 4'h4;
    localparam logic [3:0] UART_RX_CTRL   = 4'h8;

    localparam int ST_EMPTY = 4;
    localparam int ST_FULL  = 5;
    localparam int ST_PERR  = 6;
    localparam int ST_OVR   = 7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_CAPT = 2'd1,
        S_CLR  = 2'd2,
        S_LOW  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver handshake plus CPU register bus; master drives rx flag/data and CPU strobes, slave is the controller.
interface uart_rx_ctrl_if #(parameter int NBIT = 8);
    logic            rx_flag;
    logic [NBIT-1:0] rx_data;
    logic            rx_par_err;
    logic            clr_rx_flag;
    logic [3:0]      addr;
    logic            rd_en;
    logic            wr_en;
    logic [31:0]     wr_data;
    logic [31:0]     rd_data;
    logic            irq;

    modport master (
        output rx_flag, rx_data, rx_par_err, addr, rd_en, wr_en, wr_data,
        input  clr_rx_flag, rd_data, irq
    );

    modport slave (
        input  rx_flag, rx_data, rx_par_err, addr, rd_en, wr_en, wr_data,
        output clr_rx_flag, rd_data, irq
    );
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO holding received bytes; push lands on the clock edge, head is visible the same cycle.
// No backpressure: a push while full is ignored unless a pop happens in the same cycle.
module uart_rx_ctrl_fifo #(
    parameter int NBIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [NBIT-1:0]        push_dat,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [NBIT-1:0]        head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NBIT-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            wr_ok;
    logic            rd_ok;

    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !rd_ok)      cnt <= cnt + CW'(1);
            else if (rd_ok && !wr_ok) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_dat;
    end

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures flagged bytes into a FIFO, exposes DATA/STATUS/CTRL registers and a level irq.
// Byte readable 2 clks after rx_flag rises; irq registered, 1 clk after its cause; full FIFO drops bytes and sets OVR.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int NBIT         = 8,
    parameter int DEPTH        = 4,
    parameter bit DROP_BAD_PAR = 1'b1
) (
    input logic           clk,
    input logic           reset,
    uart_rx_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_t       state;
    rx_state_t       state_nxt;
    logic            low_cnt;
    logic            low_cnt_nxt;
    logic            cap;
    logic            clr;
    logic [1:0]      ctrl;
    logic            perr;
    logic            ovr;
    logic            irq_q;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [NBIT-1:0] head;
    logic            sel_data;
    logic            sel_status;
    logic            sel_ctrl;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            perr_set;
    logic            ovr_set;
    logic            clr_perr;
    logic            clr_ovr;
    logic [31:0]     status;
    logic [31:0]     rd_mux;
    logic            unused_wr_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_WAIT;
            low_cnt <= 1'b0;
        end else begin
            state   <= state_nxt;
            low_cnt <= low_cnt_nxt;
        end
    end

    // S_LOW waits for the receiver to drop its flag; a flag still high on the second cycle gets another clear.
    always_comb begin
        state_nxt   = state;
        low_cnt_nxt = low_cnt;
        cap         = 1'b0;
        clr         = 1'b0;
        unique case (state)
            S_WAIT: if (bus.rx_flag) state_nxt = S_CAPT;
            S_CAPT: begin
                cap       = 1'b1;
                state_nxt = S_CLR;
            end
            S_CLR: begin
                clr         = 1'b1;
                low_cnt_nxt = 1'b0;
                state_nxt   = S_LOW;
            end
            S_LOW: begin
                if (!bus.rx_flag)  state_nxt = S_WAIT;
                else if (low_cnt)  state_nxt = S_CLR;
                else               low_cnt_nxt = 1'b1;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign sel_data   = (bus.addr == UART_RX_DATA);
    assign sel_status = (bus.addr == UART_RX_STATUS);
    assign sel_ctrl   = (bus.addr == UART_RX_CTRL);

    assign pop      = bus.rd_en && sel_data && !empty;
    assign perr_set = cap && ctrl[CTRL_EN] && bus.rx_par_err;
    assign push_req = cap && ctrl[CTRL_EN] && !(bus.rx_par_err && DROP_BAD_PAR);
    assign push     = push_req && (!full || pop);
    assign ovr_set  = push_req && full && !pop;
    assign clr_perr = bus.wr_en && sel_status && bus.wr_data[ST_PERR];
    assign clr_ovr  = bus.wr_en && sel_status && bus.wr_data[ST_OVR];

    uart_rx_ctrl_fifo #(.NBIT(NBIT), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (bus.rx_data),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .head     (head)
    );

    // A set event in the same cycle as a W1C wins, so no error is silently lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl  <= '0;
            perr  <= 1'b0;
            ovr   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (bus.wr_en && sel_ctrl) ctrl <= bus.wr_data[1:0];
            perr  <= perr_set | (perr & ~clr_perr);
            ovr   <= ovr_set  | (ovr  & ~clr_ovr);
            irq_q <= ctrl[CTRL_IRQ_EN] & (~empty | perr | ovr);
        end
    end

    always_comb begin
        status           = '0;
        status[3:0]      = 4'(count);
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_PERR]  = perr;
        status[ST_OVR]   = ovr;
    end

    always_comb begin
        rd_mux = '0;
        if (sel_data && !empty) rd_mux = 32'(head);
        else if (sel_status)    rd_mux = status;
        else if (sel_ctrl)      rd_mux = 32'(ctrl);
    end

    assign bus.rd_data     = rd_mux;
    assign bus.clr_rx_flag = clr;
    assign bus.irq         = irq_q;

    assign unused_wr_bits = ^{bus.wr_data[31:8], bus.wr_data[5:2]};
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic against a queue-based register model.
module tb_uart_rx_ctrl;
    localparam int         NBIT     = 8;
    localparam int         DEPTH    = 4;
    localparam bit         DROP     = 1'b1;
    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_NONE   = 4'hC;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_perr;
    logic       m_ovr;
    logic       m_en;
    logic       m_irqen;

    uart_rx_ctrl_if #(.NBIT(NBIT)) bus ();

    uart_rx_ctrl #(.NBIT(NBIT), .DEPTH(DEPTH), .DROP_BAD_PAR(DROP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[3:0] = 4'(mq.size());
        s[4]   = (mq.size() == 0);
        s[5]   = (mq.size() == DEPTH);
        s[6]   = m_perr;
        s[7]   = m_ovr;
        return s;
    endfunction

    function automatic logic exp_irq();
        return m_irqen && ((mq.size() != 0) || m_perr || m_ovr);
    endfunction

    function automatic void model_rx(input logic [7:0] b, input logic pe);
        if (m_en) begin
            if (pe) m_perr = 1'b1;
            if (!(pe && DROP)) begin
                if (mq.size() == DEPTH) m_ovr = 1'b1;
                else                    mq.push_back(b);
            end
        end
    endfunction

    function automatic logic [31:0] model_pop();
        if (mq.size() == 0) return 32'h0;
        return {24'h0, mq.pop_front()};
    endfunction

    task automatic peek(input logic [3:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] v);
        bus.addr    = a;
        bus.wr_data = v;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        #1;
        d = bus.rd_data;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    // Receiver model: flag stays up until the controller's clear pulse has been seen.
    task automatic send_byte(input logic [7:0] b, input logic pe, output int pulses);
        pulses         = 0;
        bus.rx_data    = b;
        bus.rx_par_err = pe;
        bus.rx_flag    = 1'b1;
        for (int i = 0; i < 12 && bus.rx_flag; i++) begin
            @(negedge clk);
            if (bus.clr_rx_flag) pulses++;
            else if (pulses > 0) bus.rx_flag = 1'b0;
        end
        bus.rx_flag    = 1'b0;
        bus.rx_par_err = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.clr_rx_flag) pulses++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL reset_status got %h want %h", d, 32'h10); end
        peek(A_CTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
        peek(A_DATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", d); end
        n_checks++; if (bus.clr_rx_flag !== 1'b0) begin n_fail++; $display("FAIL reset_clr got %b want 0", bus.clr_rx_flag); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.irq); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        int p = 0;
        cpu_write(A_CTRL, 32'h1);
        m_en = 1'b1; m_irqen = 1'b0;
        bus.addr = A_STATUS; bus.rx_data = 8'hA5; bus.rx_par_err = 1'b0; bus.rx_flag = 1'b1;
        @(negedge clk);
        if (bus.clr_rx_flag) p++;
        d = bus.rd_data;
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL single_lat1 got %h want %h", d, 32'h10); end
        @(negedge clk);
        if (bus.clr_rx_flag) p++;
        d = bus.rd_data;
        n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL single_lat2 got %h want %h", d, 32'h01); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.clr_rx_flag) p++;
            if (i == 0) bus.rx_flag = 1'b0;
        end
        model_rx(8'hA5, 1'b0);
        n_checks++; if (p != 1) begin n_fail++; $display("FAIL single_clr_pulses got %0d want 1", p); end
        cpu_read(A_DATA, d);
        n_checks++; if (d !== model_pop()) begin n_fail++; $display("FAIL single_data got %h want %h", d, 32'hA5); end
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL single_status_after got %h want %h", d, 32'h10); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int p;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b0, p);
            model_rx(8'(i), 1'b0);
        end
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'hA4) begin n_fail++; $display("FAIL ovr_status got %h want %h", d, 32'hA4); end
        for (int i = 1; i <= 5; i++) begin
            logic [31:0] e;
            e = (i <= 4) ? 32'(i) : 32'h0;
            cpu_read(A_DATA, d);
            void'(model_pop());
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL ovr_read%0d got %h want %h", i, d, e); end
        end
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h90) begin n_fail++; $display("FAIL ovr_status_drained got %h want %h", d, 32'h90); end
        cpu_write(A_STATUS, 32'h80);
        m_ovr = 1'b0;
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL ovr_w1c got %h want %h", d, 32'h10); end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        int p;
        cpu_write(A_CTRL, 32'h3);
        m_irqen = 1'b1;
        send_byte(8'h3C, 1'b1, p);
        model_rx(8'h3C, 1'b1);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h50) begin n_fail++; $display("FAIL perr_status got %h want %h", d, 32'h50); end
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL perr_irq got %b want 1", bus.irq); end
        cpu_write(A_STATUS, 32'h40);
        m_perr = 1'b0;
        @(negedge clk);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL perr_w1c got %h want %h", d, 32'h10); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL perr_irq_clr got %b want 0", bus.irq); end
        // W1C landing in the capture cycle must not hide the new error
        bus.rx_data = 8'h11; bus.rx_par_err = 1'b1; bus.rx_flag = 1'b1;
        @(negedge clk);
        bus.addr = A_STATUS; bus.wr_data = 32'h40; bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(negedge clk);
        bus.rx_flag = 1'b0; bus.rx_par_err = 1'b0;
        repeat (2) @(negedge clk);
        model_rx(8'h11, 1'b1);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h50) begin n_fail++; $display("FAIL perr_w1c_race got %h want %h", d, 32'h50); end
        cpu_write(A_STATUS, 32'h40);
        m_perr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  bytes [4];
        int p;
        cpu_write(A_CTRL, 32'h1);
        m_irqen = 1'b0;
        bus.rx_data = 8'h5A; bus.rx_par_err = 1'b0; bus.rx_flag = 1'b1;
        @(negedge clk);
        bus.addr = A_DATA; bus.rd_en = 1'b1;
        #1 d = bus.rd_data;
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_empty_read got %h want 0", d); end
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        bus.rx_flag = 1'b0;
        repeat (2) @(negedge clk);
        model_rx(8'h5A, 1'b0);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL b2b_empty_kept got %h want %h", d, 32'h01); end
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30; bytes[3] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], 1'b0, p);
            model_rx(bytes[i], 1'b0);
        end
        bus.rx_data = 8'h99; bus.rx_flag = 1'b1;
        @(negedge clk);
        bus.addr = A_DATA; bus.rd_en = 1'b1;
        #1 d = bus.rd_data;
        n_checks++; if (d !== model_pop()) begin n_fail++; $display("FAIL b2b_full_read got %h want %h", d, 32'h5A); end
        model_rx(8'h99, 1'b0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
        bus.rx_flag = 1'b0;
        repeat (2) @(negedge clk);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h24) begin n_fail++; $display("FAIL b2b_full_status got %h want %h", d, 32'h24); end
        for (int i = 0; i < 4; i++) begin
            cpu_read(A_DATA, d);
            void'(model_pop());
            n_checks++; if (d !== 32'(bytes[i])) begin n_fail++; $display("FAIL b2b_drain%0d got %h want %h", i, d, bytes[i]); end
        end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        int p;
        cpu_write(A_CTRL, 32'h0);
        m_en = 1'b0;
        send_byte(8'h77, 1'b0, p);
        model_rx(8'h77, 1'b0);
        n_checks++; if (p != 1) begin n_fail++; $display("FAIL dis_clr_pulses got %0d want 1", p); end
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL dis_status got %h want %h", d, 32'h10); end
        send_byte(8'h55, 1'b1, p);
        model_rx(8'h55, 1'b1);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL dis_perr_status got %h want %h", d, 32'h10); end
    endtask

    task automatic test_stuck_flag();
        logic [31:0] d;
        int p = 0;
        cpu_write(A_CTRL, 32'h1);
        m_en = 1'b1;
        bus.rx_data = 8'hC3; bus.rx_par_err = 1'b0; bus.rx_flag = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.clr_rx_flag) p++;
        end
        bus.rx_flag = 1'b0;
        repeat (3) @(negedge clk);
        model_rx(8'hC3, 1'b0);
        n_checks++; if (p != 3) begin n_fail++; $display("FAIL stuck_clr_pulses got %0d want 3", p); end
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL stuck_status got %h want %h", d, 32'h01); end
        cpu_read(A_DATA, d);
        n_checks++; if (d !== model_pop()) begin n_fail++; $display("FAIL stuck_data got %h want %h", d, 32'hC3); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] w;
        logic [7:0]  b;
        logic        pe;
        int          op;
        int          p;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: begin
                    b  = 8'($urandom);
                    pe = ($urandom_range(0, 4) == 0);
                    send_byte(b, pe, p);
                    model_rx(b, pe);
                    n_checks++; if (p != 1) begin n_fail++; $display("FAIL rand_clr_pulses it=%0d got %0d want 1", it, p); end
                end
                4, 5: begin
                    cpu_read(A_DATA, d);
                    e = model_pop();
                    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_data it=%0d got %h want %h", it, d, e); end
                end
                6: begin
                    w = $urandom;
                    cpu_write(A_STATUS, w);
                    if (w[7]) m_ovr  = 1'b0;
                    if (w[6]) m_perr = 1'b0;
                end
                7: begin
                    w    = $urandom;
                    w[0] = ($urandom_range(0, 3) != 0);
                    cpu_write(A_CTRL, w);
                    m_en = w[0]; m_irqen = w[1];
                    peek(A_CTRL, d);
                    n_checks++; if (d !== {30'h0, w[1:0]}) begin n_fail++; $display("FAIL rand_ctrl it=%0d got %h want %h", it, d, {30'h0, w[1:0]}); end
                end
                8: cpu_write(A_DATA, $urandom);
                default: begin
                    peek(A_NONE, d);
                    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rand_unmapped it=%0d got %h want 0", it, d); end
                    cpu_write(A_NONE, $urandom);
                end
            endcase
            @(negedge clk);
            peek(A_STATUS, d);
            e = exp_status();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_status it=%0d op=%0d got %h want %h", it, op, d, e); end
            n_checks++; if (bus.irq !== exp_irq()) begin n_fail++; $display("FAIL rand_irq it=%0d got %b want %b", it, bus.irq, exp_irq()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int p;
        int k = 0;
        for (int i = 0; i < DEPTH; i++) cpu_read(A_DATA, d);
        cpu_write(A_STATUS, 32'hC0);
        cpu_write(A_CTRL, 32'h3);
        mq.delete(); m_perr = 1'b0; m_ovr = 1'b0; m_en = 1'b1; m_irqen = 1'b1;
        send_byte(8'h21, 1'b0, p);
        send_byte(8'h22, 1'b0, p);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL rstmid_pre_status got %h want %h", d, 32'h02); end
        bus.rx_data = 8'h23; bus.rx_par_err = 1'b1; bus.rx_flag = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.clr_rx_flag && k < 6);
        n_checks++; if (bus.clr_rx_flag !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_clr got %b want 1", bus.clr_rx_flag); end
        reset = 1'b0; bus.rx_flag = 1'b0; bus.rx_par_err = 1'b0;
        #1;
        n_checks++; if (bus.clr_rx_flag !== 1'b0) begin n_fail++; $display("FAIL rstmid_clr_async got %b want 0", bus.clr_rx_flag); end
        @(negedge clk);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL rstmid_status got %h want %h", d, 32'h10); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b want 0", bus.irq); end
        peek(A_CTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl got %h want 0", d); end
        reset = 1'b1;
        mq.delete(); m_perr = 1'b0; m_ovr = 1'b0; m_en = 1'b0; m_irqen = 1'b0;
        repeat (2) @(negedge clk);
        peek(A_STATUS, d);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL rstmid_post_status got %h want %h", d, 32'h10); end
    endtask

    initial begin
        reset = 1'b0;
        bus.rx_flag = 1'b0; bus.rx_data = '0; bus.rx_par_err = 1'b0;
        bus.addr = '0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
        m_perr = 1'b0; m_ovr = 1'b0; m_en = 1'b0; m_irqen = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_back_to_back();
        test_disable();
        test_stuck_flag();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
